mat_uart_streamer: RTL
======================

Name: mat_uart_streamer

Overview:
- Parametrised successor to the matrix-result UART path.
- On a start request, streams a ROWS x COLS matrix out of a synchronous-read matrix memory over a built-in UART 8N1 transmitter.
- Order: row-major; each element is ELEM_W bits, sent as ELEM_W/8 bytes, most-significant byte first.
- Sits between the matrix R memory read port and the board TX pin. Replaces the fixed 2x2, 8-bit, bclk-domain streamer with a single-clock design.

Parameters:
- ROWS, 2, matrix row count (>=1)
- COLS, 2, matrix column count (>=1)
- ELEM_W, 8, element width in bits; must be a multiple of 8, range 8..32
- BAUD_DIV, 10417, clk cycles per UART bit (100 MHz / 9600); must be >=2
- ADDR_W, 6, memory address width; ROWS*COLS must be <= 2**ADDR_W

Ports:
- clk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-low reset
- start  in  1  rising edge requests a matrix transfer
- abort  in  1  level; finish the current byte, then stop
- rd_en  out  1  memory read strobe, one cycle wide
- rd_addr  out  ADDR_W  element address = row*COLS + col
- rd_data  in  ELEM_W  memory data, valid the cycle after rd_en
- tx_data  out  1  UART serial line, idles high
- busy  out  1  high from the accepted start until return to IDLE
- done  out  1  one-cycle pulse when the full matrix has been sent
- aborted  out  1  one-cycle pulse when the transfer ended by abort
- elem_idx  out  ADDR_W  index of the element currently being sent

Behaviour:
- Reset (rst==0 at a clk edge):
  - State goes to IDLE.
  - tx_data=1; busy=0; done=0; aborted=0; rd_en=0; rd_addr=0; elem_idx=0.
  - Baud counter, bit counter and start-edge register are cleared.
  - Reset mid-frame truncates the frame immediately; the line returns high on the next cycle.
- Start detection: register start each cycle; start_pulse = start & ~start_q.
  - Accepted only in IDLE.
  - Ignored while busy; it is not queued.
- State machine:
  - IDLE: on start_pulse, busy=1, elem_idx=0, go to FETCH.
  - FETCH: rd_en=1, rd_addr=elem_idx, go to WAIT.
  - WAIT: latch rd_data into the element register, byte_idx=ELEM_W/8-1, go to LOAD.
  - LOAD: load shift register {1, byte[byte_idx], 0}, clear baud and bit counters, go to SEND.
  - SEND: drive the shift LSB; every BAUD_DIV cycles, shift and increment the bit count. After 10 bits (start, D0..D7 LSB first, stop), go to NEXT.
  - NEXT, in priority order:
    - If abort is high: aborted pulse, go to IDLE.
    - Else if byte_idx>0: decrement byte_idx, go to LOAD.
    - Else if elem_idx==ROWS*COLS-1: done pulse, go to IDLE.
    - Else: elem_idx+1, go to FETCH.
- Timing, with the start bit beginning the cycle after LOAD:
  - Start bit is driven 4 cycles after the start_pulse edge (FETCH, WAIT, LOAD).
  - Next byte of the same element: 2 idle-high cycles after the stop bit (NEXT, LOAD).
  - Next element: 4 idle-high cycles after the stop bit (NEXT, FETCH, WAIT, LOAD).
  - Each frame lasts exactly 10*BAUD_DIV cycles.
- Abort:
  - Sampled only in NEXT, so a byte is never truncated.
  - If abort and the final byte coincide, abort wins: aborted=1, done=0.
- busy drops in the same cycle that done or aborted pulses.
- Counters: elem_idx has ADDR_W bits and never wraps, because the terminal compare happens first. Baud counter is clog2(BAUD_DIV) bits; bit counter is 4 bits.
- Read contract: rd_data is registered only in WAIT. Changes on rd_data at any other time have no effect.

Optional Feature:
- Macro: MAT_UART_ROW_DELIM_EN
- Defined:
  - After the last byte of an element where col==COLS-1, one extra frame carrying 0x0A (LF) is sent before the next FETCH or before done.
  - Abort is also honoured after the LF frame.
  - Total frames per transfer = ROWS*COLS*ELEM_W/8 + ROWS.
- Undefined: no delimiter frames; the LF logic is absent from the netlist.

Test Plan:
- Reset/idle: hold rst=0 for 5 cycles, then release. tx_data=1, busy=0, done=0, rd_en=0; no activity over 100 cycles.
- Basic 2x2, ELEM_W=8, BAUD_DIV=4, memory={0x11,0x22,0xA5,0xFF}, start pulse:
  - rd_addr sequence 0,1,2,3.
  - Decoded bytes 11,22,A5,FF.
  - Each frame is 40 cycles.
  - done pulses once; busy falls with done.
- Wide element, ELEM_W=16, 1x2, memory={0x1234,0xBEEF}:
  - Bytes 12,34,BE,EF.
  - 2-cycle gap between 12 and 34; 4-cycle gap between 34 and BE.
- Abort: assert abort during frame 2 of the 2x2 case.
  - Frame 2 completes intact; no frame 3.
  - aborted=1 for one cycle, done never asserts, tx_data stays high.
- Start while busy and reset mid-frame:
  - Second start pulse during frame 1 is ignored; exactly 4 frames are sent.
  - rst=0 in the middle of a frame: tx_data=1 next cycle, busy=0.
  - A new start then sends from element 0.
- With MAT_UART_ROW_DELIM_EN, 2x2 8-bit case: bytes 11,22,0A,A5,FF,0A, then done.

Source files
------------

// File: rtl/mat_uart_streamer.sv
// mat_uart_streamer: streams a ROWS x COLS matrix out of a synchronous-read
// memory over a built-in UART 8N1 transmitter. Elements go out row-major,
// each as ELEM_W/8 bytes, most-significant byte first.
// Optional feature macro: MAT_UART_ROW_DELIM_EN appends an LF (0x0A) frame
// after the last element of every row.
// Memory read contract: rd_en is a one-cycle strobe with rd_addr valid in the
// same cycle; the memory returns rd_data on the following cycle, and rd_data
// is sampled only then (in WAIT). There is no back-pressure in either direction.
module mat_uart_streamer #(
    parameter int ROWS     = 2,
    parameter int COLS     = 2,
    parameter int ELEM_W   = 8,
    parameter int BAUD_DIV = 10417,
    parameter int ADDR_W   = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [ELEM_W-1:0] rd_data,
    output logic              tx_data,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [ADDR_W-1:0] elem_idx
);

    localparam int BYTES  = ELEM_W / 8;
    localparam int BI_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int BAUD_W = $clog2(BAUD_DIV);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
    localparam logic [BI_W-1:0]   BYTE_LAST = BI_W'(BYTES - 1);
    localparam logic [ADDR_W-1:0] ELEM_LAST = ADDR_W'(ROWS * COLS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_LOAD,
        S_SEND,
        S_NEXT
    } state_t;

    state_t state, state_n;

    logic              start_q;
    logic              start_pulse;
    logic [ELEM_W-1:0] elem_reg;
    logic [BI_W-1:0]   byte_idx;
    logic [9:0]        shift_reg;
    logic [BAUD_W-1:0] baud_cnt;
    logic [3:0]        bit_cnt;
    logic              frame_end;
    logic [7:0]        cur_byte;

    // NEXT-state decisions, mutually exclusive, in priority order
    logic nxt_abort;
    logic nxt_byte;
    logic nxt_done;
    logic nxt_elem;

`ifdef MAT_UART_ROW_DELIM_EN
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    logic             nxt_lf;
    logic             lf_phase;   // the frame just loaded/sent is the LF delimiter
    logic [COL_W-1:0] col_cnt;    // column of the element at elem_idx
`endif

    assign start_pulse = start & ~start_q;
    assign frame_end   = (state == S_SEND) && (baud_cnt == BAUD_LAST) && (bit_cnt == 4'd9);

    // Byte to put on the line for the next frame
    always_comb begin
        cur_byte = elem_reg[int'(byte_idx) * 8 +: 8];
`ifdef MAT_UART_ROW_DELIM_EN
        if (lf_phase) cur_byte = 8'h0A;
`endif
    end

    // End-of-frame decision: abort first, then more bytes, delimiter, last element
    always_comb begin
        nxt_abort = 1'b0;
        nxt_byte  = 1'b0;
        nxt_done  = 1'b0;
        nxt_elem  = 1'b0;
`ifdef MAT_UART_ROW_DELIM_EN
        nxt_lf    = 1'b0;
`endif
        if (state == S_NEXT) begin
            if (abort) nxt_abort = 1'b1;
            else if (byte_idx != '0) nxt_byte = 1'b1;
`ifdef MAT_UART_ROW_DELIM_EN
            else if (!lf_phase && (col_cnt == COL_LAST)) nxt_lf = 1'b1;
`endif
            else if (elem_idx == ELEM_LAST) nxt_done = 1'b1;
            else nxt_elem = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_n = state;
        rd_en   = 1'b0;
        rd_addr = '0;
        tx_data = 1'b1;
        busy    = (state != S_IDLE);
        case (state)
            S_IDLE:  if (start_pulse) state_n = S_FETCH;
            S_FETCH: begin
                rd_en   = 1'b1;
                rd_addr = elem_idx;
                state_n = S_WAIT;
            end
            S_WAIT:  state_n = S_LOAD;
            S_LOAD:  state_n = S_SEND;
            S_SEND: begin
                tx_data = shift_reg[0];
                if (frame_end) state_n = S_NEXT;
            end
            S_NEXT: begin
                if (nxt_abort || nxt_done) state_n = S_IDLE;
                else if (nxt_elem)         state_n = S_FETCH;
                else                       state_n = S_LOAD;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Datapath: element capture, shift register, baud/bit counters, pulses
    always_ff @(posedge clk) begin
        if (!rst) begin
            start_q   <= 1'b0;
            elem_idx  <= '0;
            elem_reg  <= '0;
            byte_idx  <= '0;
            shift_reg <= '1;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            done      <= 1'b0;
            aborted   <= 1'b0;
`ifdef MAT_UART_ROW_DELIM_EN
            lf_phase  <= 1'b0;
            col_cnt   <= '0;
`endif
        end else begin
            start_q <= start;
            done    <= nxt_done;
            aborted <= nxt_abort;
            case (state)
                S_IDLE: begin
                    if (start_pulse) begin
                        elem_idx <= '0;
`ifdef MAT_UART_ROW_DELIM_EN
                        col_cnt  <= '0;
                        lf_phase <= 1'b0;
`endif
                    end
                end
                S_WAIT: begin
                    elem_reg <= rd_data;
                    byte_idx <= BYTE_LAST;
                end
                S_LOAD: begin
                    shift_reg <= {1'b1, cur_byte, 1'b0};
                    baud_cnt  <= '0;
                    bit_cnt   <= '0;
                end
                S_SEND: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt  <= '0;
                        shift_reg <= {1'b1, shift_reg[9:1]};
                        bit_cnt   <= bit_cnt + 4'd1;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_NEXT: begin
                    if (nxt_byte) byte_idx <= byte_idx - 1'b1;
                    if (nxt_elem) elem_idx <= elem_idx + 1'b1;
`ifdef MAT_UART_ROW_DELIM_EN
                    lf_phase <= nxt_lf;
                    if (nxt_elem) col_cnt <= (col_cnt == COL_LAST) ? '0 : col_cnt + 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule
